// File: rtl/upower_multicycle_ctrl_if.sv
// Memory port bundle for the uPOWER multi-cycle controller.
// Master issues rd/wr strobes; slave answers with mem_ready.
interface upower_multicycle_ctrl_if;
   logic mem_rd;
   logic mem_wr;
   logic mem_ready;

   modport master (
      output mem_rd,
      output mem_wr,
      input  mem_ready
   );

   modport slave (
      input  mem_rd,
      input  mem_wr,
      output mem_ready
   );
endinterface

// File: rtl/upower_multicycle_ctrl.sv
// Multi-cycle control FSM for the uPOWER datapath subset.
// Optional performance counters are built when PERF_CNT_EN is defined.
module upower_multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       run,
   input  logic [31:0]                instr,
   input  logic                       br_taken,
   upower_multicycle_ctrl_if.master   mem,
   output logic [1:0]                 alu_op,
   output logic                       alu_src_b,
   output logic [1:0]                 imm_sel,
   output logic                       pc_src,
   output logic                       pc_we,
   output logic                       ir_we,
   output logic                       reg_we,
   output logic                       mem_to_reg,
   output logic                       busy,
   output logic                       illegal,
   output logic                       bus_err,
   output logic [3:0]                 state_o
`ifdef PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]           cycle_cnt,
   output logic [CNT_W-1:0]           instr_cnt
`endif
);

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      ADDR   = 4'd3,
      MEM_RD = 4'd4,
      MEM_WR = 4'd5,
      WB_MEM = 4'd6,
      EXEC_I = 4'd7,
      EXEC_R = 4'd8,
      WB_ALU = 4'd9,
      BRANCH = 4'd10,
      TRAP   = 4'd15
   } state_t;

   state_t     state;
   state_t     nxt;
   state_t     dec_tgt;
   logic [7:0] wcnt;
   logic       mem_st;
   logic       tmo;
   logic       unused_ok;

   logic [5:0] opc;
   logic [8:0] xo;
   logic       is_mem;
   logic       is_bc;
   logic       is_imm;
   logic       is_xo;

   assign opc       = instr[31:26];
   assign xo        = instr[9:1];
   assign unused_ok = ^{instr[25:10], instr[0], CNT_W[0]};

   assign is_mem = (opc == 6'd58) || (opc == 6'd62);
   assign is_bc  = (opc == 6'd19);
   assign is_imm = (opc == 6'd14) || (opc == 6'd24) || (opc == 6'd28);
   assign is_xo  = (opc == 6'd31) &&
                   ((xo == 9'd28)  || (xo == 9'd40)  ||
                    (xo == 9'd266) || (xo == 9'd444) ||
                    (xo == 9'd476));

   assign mem_st  = (state == FETCH) || (state == MEM_RD) ||
                    (state == MEM_WR);
   assign tmo     = mem_st && !mem.mem_ready &&
                    (wcnt == 8'(MEM_TIMEOUT - 1));
   assign state_o = state;

   // Opcode/XO routing out of DECODE
   always_comb begin
      dec_tgt = TRAP;
      unique case (1'b1)
         is_mem:  dec_tgt = ADDR;
         is_bc:   dec_tgt = BRANCH;
         is_imm:  dec_tgt = EXEC_I;
         is_xo:   dec_tgt = EXEC_R;
         default: dec_tgt = TRAP;
      endcase
   end

   // State register, watchdog counter and sticky error flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         wcnt    <= 8'd0;
         illegal <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         state <= nxt;
         if (nxt != state)
            wcnt <= 8'd0;
         else if (mem_st && !mem.mem_ready)
            wcnt <= wcnt + 8'd1;
         if ((state == DECODE) && (nxt == TRAP))
            illegal <= 1'b1;
         if (tmo)
            bus_err <= 1'b1;
      end
   end

   // Next-state sequencing
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:   if (run) nxt = FETCH;
         FETCH: begin
            if (mem.mem_ready) nxt = run ? DECODE : IDLE;
            else if (tmo)      nxt = TRAP;
         end
         DECODE: nxt = dec_tgt;
         ADDR:   nxt = (opc == 6'd58) ? MEM_RD : MEM_WR;
         MEM_RD: begin
            if (mem.mem_ready) nxt = WB_MEM;
            else if (tmo)      nxt = TRAP;
         end
         MEM_WR: begin
            if (mem.mem_ready) nxt = FETCH;
            else if (tmo)      nxt = TRAP;
         end
         WB_MEM: nxt = FETCH;
         EXEC_I: nxt = WB_ALU;
         EXEC_R: nxt = WB_ALU;
         WB_ALU: nxt = FETCH;
         BRANCH: nxt = FETCH;
         TRAP:   nxt = TRAP;
         default: nxt = IDLE;
      endcase
   end

   // Datapath strobes decoded from the current state
   always_comb begin
      alu_op     = 2'b00;
      alu_src_b  = 1'b0;
      imm_sel    = 2'd0;
      pc_src     = 1'b0;
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      mem.mem_rd = 1'b0;
      mem.mem_wr = 1'b0;
      reg_we     = 1'b0;
      mem_to_reg = 1'b0;
      busy       = (state != IDLE) && (state != TRAP);
      unique case (state)
         FETCH: begin
            mem.mem_rd = 1'b1;
            ir_we      = mem.mem_ready;
            pc_we      = mem.mem_ready;
         end
         ADDR: begin
            alu_src_b = 1'b1;
            imm_sel   = 2'd1;
         end
         MEM_RD: mem.mem_rd = 1'b1;
         MEM_WR: mem.mem_wr = 1'b1;
         WB_MEM: begin
            reg_we     = 1'b1;
            mem_to_reg = 1'b1;
         end
         EXEC_I: begin
            alu_op    = 2'b10;
            alu_src_b = 1'b1;
         end
         EXEC_R: alu_op = 2'b10;
         WB_ALU: reg_we = 1'b1;
         BRANCH: begin
            alu_op  = 2'b01;
            imm_sel = 2'd2;
            pc_src  = 1'b1;
            pc_we   = br_taken;
         end
         default: ;
      endcase
   end

`ifdef PERF_CNT_EN
   logic done;
   assign done = (nxt == FETCH) &&
                 ((state == WB_MEM) || (state == WB_ALU) ||
                  (state == MEM_WR) || (state == BRANCH));

   // Busy-cycle and retired-instruction counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if (busy)
            cycle_cnt <= cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         if (done)
            instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end
`endif

endmodule

// File: tb/tb_upower_multicycle_ctrl.sv
// Self-checking bench for upower_multicycle_ctrl.
// Table of instructions scored per instruction, plus corner sequences.
module tb_upower_multicycle_ctrl;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic [31:0] instr;
   logic        br_taken;
   logic [1:0]  alu_op;
   logic        alu_src_b;
   logic [1:0]  imm_sel;
   logic        pc_src;
   logic        pc_we;
   logic        ir_we;
   logic        reg_we;
   logic        mem_to_reg;
   logic        busy;
   logic        illegal;
   logic        bus_err;
   logic [3:0]  state_o;
`ifdef PERF_CNT_EN
   logic [31:0] cycle_cnt;
   logic [31:0] instr_cnt;
`endif

   upower_multicycle_ctrl_if bus ();

   upower_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .instr      (instr),
      .br_taken   (br_taken),
      .mem        (bus.master),
      .alu_op     (alu_op),
      .alu_src_b  (alu_src_b),
      .imm_sel    (imm_sel),
      .pc_src     (pc_src),
      .pc_we      (pc_we),
      .ir_we      (ir_we),
      .reg_we     (reg_we),
      .mem_to_reg (mem_to_reg),
      .busy       (busy),
      .illegal    (illegal),
      .bus_err    (bus_err),
      .state_o    (state_o)
`ifdef PERF_CNT_EN
      ,
      .cycle_cnt  (cycle_cnt),
      .instr_cnt  (instr_cnt)
`endif
   );

   typedef struct {
      logic [31:0] ins;
      logic        br;
      int          fw;
      int          mw;
      int          lat;
      int          rwe;
      int          pwe;
      int          iwe;
      int          rd;
      int          wr;
      int          m2r;
      logic [1:0]  aop;
      logic        psrc;
   } vec_t;

   localparam int NV = 14;
   vec_t tv [NV];
   vec_t sbq [$];

   int ncmp = 0;
   int nerr = 0;
   int fw   = 0;
   int mw   = 0;
   int wcnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Variable-latency memory: fw/mw idle cycles, then mem_ready
   always begin
      int lim;
      @(posedge clk);
      #2;
      if (bus.mem_rd || bus.mem_wr) begin
         lim = (state_o == 4'd1) ? fw : mw;
         if (wcnt >= lim) begin
            bus.mem_ready = 1'b1;
            wcnt = 0;
         end else begin
            bus.mem_ready = 1'b0;
            wcnt++;
         end
      end else begin
         bus.mem_ready = 1'b0;
         wcnt = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d want %0d", n, act, exp);
      end
   endtask

   task automatic wait_state(logic [3:0] s, string n);
      for (int k = 0; k < 30; k++) begin
         if (state_o == s) return;
         tick();
      end
      chk({n, " wait"}, state_o, s);
   endtask

   task automatic set_vec(int i);
      instr    = tv[i].ins;
      br_taken = tv[i].br;
      fw       = tv[i].fw;
      mw       = tv[i].mw;
      sbq.push_back(tv[i]);
   endtask

   // Observe one instruction from FETCH to the next FETCH and score it
   task automatic measure(int i);
      vec_t e;
      int   cyc = 0;
      int   rwe = 0, pwe = 0, iwe = 0, rd = 0, wr = 0, m2r = 0;
      logic [1:0] aop = 2'b00;
      logic psrc = 1'b0;
      bit   left = 0;
      bit   fin = 0;
      e = sbq.pop_front();
      for (int k = 0; k < 60; k++) begin
         rwe += int'(reg_we);
         pwe += int'(pc_we);
         iwe += int'(ir_we);
         rd  += int'(bus.mem_rd);
         wr  += int'(bus.mem_wr);
         m2r += int'(mem_to_reg);
         aop |= alu_op;
         psrc |= pc_src;
         cyc++;
         tick();
         if (state_o != 4'd1) left = 1;
         if ((left && state_o == 4'd1) || state_o == 4'd15) begin
            fin = 1;
            break;
         end
         #2;
      end
      if (!fin) $display("FAIL v%0d budget: got %0d want %0d", i, cyc, e.lat);
      chk($sformatf("v%0d end_state", i), state_o, 4'd1);
      chk($sformatf("v%0d latency", i), cyc, e.lat);
      chk($sformatf("v%0d reg_we", i), rwe, e.rwe);
      chk($sformatf("v%0d pc_we", i), pwe, e.pwe);
      chk($sformatf("v%0d ir_we", i), iwe, e.iwe);
      chk($sformatf("v%0d mem_rd", i), rd, e.rd);
      chk($sformatf("v%0d mem_wr", i), wr, e.wr);
      chk($sformatf("v%0d mem_to_reg", i), m2r, e.m2r);
      chk($sformatf("v%0d alu_op", i), aop, e.aop);
      chk($sformatf("v%0d pc_src", i), psrc, e.psrc);
   endtask

   initial begin
      int n;
      int lsum;
      bit bad;
      rst_n    = 1'b0;
      run      = 1'b1;
      instr    = 32'd0;
      br_taken = 1'b0;

      //          ins          br fw mw lat rwe pwe iwe rd wr m2r aop psrc
      tv[0]  = '{32'h38210005, 0, 0, 0, 4, 1, 1, 1, 1, 0, 0, 2'b10, 0};
      tv[1]  = '{32'h60430010, 0, 2, 0, 6, 1, 1, 1, 3, 0, 0, 2'b10, 0};
      tv[2]  = '{32'h70000FFF, 0, 0, 0, 4, 1, 1, 1, 1, 0, 0, 2'b10, 0};
      tv[3]  = '{32'h7C221214, 0, 0, 0, 4, 1, 1, 1, 1, 0, 0, 2'b10, 0};
      tv[4]  = '{32'h7C000050, 0, 1, 0, 5, 1, 1, 1, 2, 0, 0, 2'b10, 0};
      tv[5]  = '{32'h7C000038, 0, 0, 0, 4, 1, 1, 1, 1, 0, 0, 2'b10, 0};
      tv[6]  = '{32'h7C000378, 0, 0, 0, 4, 1, 1, 1, 1, 0, 0, 2'b10, 0};
      tv[7]  = '{32'h7C0003B8, 0, 3, 0, 7, 1, 1, 1, 4, 0, 0, 2'b10, 0};
      tv[8]  = '{32'hE8200008, 0, 0, 3, 8, 1, 1, 1, 5, 0, 1, 2'b00, 0};
      tv[9]  = '{32'hE8200000, 0, 0, 0, 5, 1, 1, 1, 2, 0, 1, 2'b00, 0};
      tv[10] = '{32'hF8200000, 0, 0, 2, 6, 0, 1, 1, 1, 3, 0, 2'b00, 0};
      tv[11] = '{32'h4C000000, 1, 0, 0, 3, 0, 2, 1, 1, 0, 0, 2'b01, 1};
      tv[12] = '{32'h4C000000, 0, 0, 0, 3, 0, 1, 1, 1, 0, 0, 2'b01, 1};
      tv[13] = '{32'hF8200000, 0, 0, 0, 4, 0, 1, 1, 1, 1, 0, 2'b00, 0};

      repeat (2) tick();
      #2;
      chk("reset state", state_o, 4'd0);
      chk("reset outs",
          {alu_op, alu_src_b, imm_sel, pc_src, pc_we, ir_we, bus.mem_rd,
           bus.mem_wr, reg_we, mem_to_reg, busy, illegal, bus_err}, 0);

      set_vec(0);
      rst_n = 1'b1;
      tick();
      chk("release fetch", state_o, 4'd1);
      #2;
      chk("release mem_rd", bus.mem_rd, 1'b1);
      measure(0);
      for (int i = 1; i < NV; i++) begin
         set_vec(i);
         #2;
         measure(i);
      end

`ifdef PERF_CNT_EN
      lsum = 0;
      for (int i = 0; i < NV; i++) lsum += tv[i].lat;
      chk("instr_cnt", instr_cnt, NV);
      chk("cycle_cnt", cycle_cnt, lsum);
`else
      lsum = 0;
`endif
      chk("no illegal", illegal, 1'b0);
      chk("no bus_err", bus_err, 1'b0);

      // run drops mid-instruction: finish, fetch once more, then idle
      instr = 32'h38210005;
      fw = 0;
      tick();
      run = 1'b0;
      repeat (3) tick();
      chk("rundrop fetch", state_o, 4'd1);
      tick();
      chk("rundrop idle", state_o, 4'd0);
      tick();
      chk("idle hold", state_o, 4'd0);
      run = 1'b1;
      tick();
      chk("rerun fetch", state_o, 4'd1);

      // undecodable XO traps and stays trapped
      instr = 32'h7C000006;
      tick();
      tick();
      #2;
      chk("illegal state", state_o, 4'd15);
      chk("illegal flag", illegal, 1'b1);
      chk("trap busy", busy, 1'b0);
      n = 0;
      bad = 0;
      repeat (10) begin
         tick();
         if (state_o == 4'd15) n++;
         if (bus.mem_rd || bus.mem_wr || reg_we || pc_we || ir_we) bad = 1;
      end
      chk("trap hold", n, 10);
      chk("trap strobes", bad, 1'b0);
      rst_n = 1'b0;
      tick();
      #2;
      chk("trap reset state", state_o, 4'd0);
      chk("trap reset illegal", illegal, 1'b0);

      // store hangs: watchdog trips after MEM_TIMEOUT cycles
      instr = 32'hF8200000;
      fw = 0;
      mw = 100;
      rst_n = 1'b1;
      tick();
      wait_state(4'd5, "to mem_wr");
      n = 0;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (state_o != 4'd5) break;
         n++;
         #2;
         if (bus.mem_wr !== 1'b1 || bus_err !== 1'b0) bad = 1;
         tick();
      end
      chk("timeout cycles", n, 4);
      chk("timeout pre err", bad, 1'b0);
      chk("timeout state", state_o, 4'd15);
      #2;
      chk("timeout bus_err", bus_err, 1'b1);
      chk("timeout busy", busy, 1'b0);

      // reset in the middle of a load
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      instr = 32'hE8200000;
      tick();
      wait_state(4'd4, "to mem_rd");
      tick();
      #2;
      chk("mid rd mem_rd", bus.mem_rd, 1'b1);
      rst_n = 1'b0;
      tick();
      chk("mid rd reset", state_o, 4'd0);
      #2;
      chk("mid rd drop", bus.mem_rd, 1'b0);
      chk("mid rd bus_err", bus_err, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/upower_multicycle_ctrl.md
Name: upower_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the uPOWER datapath subset: LD, STD, BC, ADDI, ORI, ANDI, and X/XO-form AND, SUB, ADD, OR, NAND.
- Sequences fetch, decode, execute, memory and writeback.
- Drives ALUOp into the existing ALU control unit, plus all datapath enables and muxes.
- Handshakes with a variable-latency memory port; a watchdog catches hung transfers.

Parameters:
- MEM_TIMEOUT, 16, max cycles waiting on mem_ready in any memory state before bus error (legal range 1..255).
- CNT_W, 32, width of performance counters (used only with PERF_CNT_EN).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- run  in  1  level; FSM leaves IDLE only while high.
- instr  in  32  current IR contents. Opcode = instr[31:26]; XO = instr[9:1].
- mem_ready  in  1  memory completes the current rd/wr this cycle.
- br_taken  in  1  BC condition result from the CR/CTR logic, valid in BRANCH.
- alu_op  out  2  to the ALU control unit: 00 add (address/PC), 01 branch compare, 10 decode by OpCode/XO.
- alu_src_b  out  1  0 = register B, 1 = immediate.
- imm_sel  out  2  0 = SI (D-form), 1 = DS<<2, 2 = BD<<2.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- pc_we, ir_we, mem_rd, mem_wr, reg_we, mem_to_reg  out  1 each  datapath strobes.
- busy  out  1  high in any state other than IDLE or TRAP.
- illegal  out  1  sticky; set on an undecodable instruction.
- bus_err  out  1  sticky; set on a memory timeout.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Reset (rst_n low at a clock edge): state = IDLE; all outputs 0; illegal = 0, bus_err = 0; wait counter = 0.
- Reset takes priority in every state, including mid-transfer. mem_rd and mem_wr drop the cycle after reset is sampled.
- State encodings: IDLE = 0, FETCH = 1, DECODE = 2, ADDR = 3, MEM_RD = 4, MEM_WR = 5, WB_MEM = 6, EXEC_I = 7, EXEC_R = 8, WB_ALU = 9, BRANCH = 10, TRAP = 15.
- Outputs are decoded from the state register (Moore), with three exceptions: ir_we and pc_we in FETCH are gated by mem_ready, and pc_we in BRANCH is gated by br_taken.
- IDLE: if run = 1, go to FETCH; otherwise stay.
- FETCH: mem_rd = 1, alu_op = 00, pc_src = 0.
  - On mem_ready: ir_we = 1, pc_we = 1; if run = 1 go to DECODE, otherwise go to IDLE after the IR update.
- DECODE (1 cycle, no strobes): route by opcode.
  - 58 or 62 -> ADDR.
  - 19 -> BRANCH.
  - 14, 24, 28 -> EXEC_I.
  - 31 with XO in {28, 40, 266, 444, 476} -> EXEC_R.
  - Anything else -> TRAP with illegal = 1.
- ADDR: alu_op = 00, alu_src_b = 1, imm_sel = 1. Go to MEM_RD if opcode = 58, else MEM_WR.
- MEM_RD: mem_rd = 1; on mem_ready go to WB_MEM.
- WB_MEM: reg_we = 1, mem_to_reg = 1; go to FETCH.
- MEM_WR: mem_wr = 1; on mem_ready go to FETCH.
- EXEC_I: alu_op = 10, alu_src_b = 1, imm_sel = 0; go to WB_ALU.
- EXEC_R: alu_op = 10, alu_src_b = 0; go to WB_ALU.
- WB_ALU: reg_we = 1, mem_to_reg = 0; go to FETCH.
- BRANCH: alu_op = 01, imm_sel = 2, pc_src = 1, pc_we = br_taken; go to FETCH.
- Watchdog (FETCH, MEM_RD, MEM_WR):
  - Counter clears on entry to each of these states and increments each cycle mem_ready = 0.
  - When the counter reaches MEM_TIMEOUT with mem_ready still 0: go to TRAP, set bus_err = 1, no strobe issued.
  - mem_ready = 1 in the same cycle the counter hits the limit counts as success.
- TRAP: all strobes 0; held until reset. The run input is ignored.
- Latency per instruction, with F = number of fetch-wait cycles:
  - ALU ops: F + 4 cycles.
  - BC: F + 3 cycles.
  - LD: F + 5 + (MEM_RD wait) cycles.
  - STD: F + 4 + (MEM_WR wait) cycles.
  - Zero-wait memory means mem_ready is high on the first cycle of the state.
- run dropping mid-instruction: the current instruction completes; the next FETCH is still entered, and its completion returns to IDLE.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[CNT_W-1:0] and instr_cnt[CNT_W-1:0], both 0 on reset.
  - cycle_cnt increments every cycle busy = 1.
  - instr_cnt increments on each completion: transition into FETCH from WB_MEM, WB_ALU, MEM_WR or BRANCH.
  - Both wrap modulo 2^CNT_W.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset/idle: rst_n = 0 for 2 cycles with run = 1 -> state_o = 0 and all outputs 0. Release reset -> FETCH next cycle, mem_rd = 1.
- ADDI (instr = 0x38210005), mem_ready always 1 -> states 1, 2, 7, 9, 1. alu_op = 10 in EXEC_I; reg_we pulses for exactly 1 cycle; instr_cnt = 1 when PERF_CNT_EN is defined.
- LD (opcode 58), mem_ready delayed 3 cycles in MEM_RD -> mem_rd held 4 cycles, then WB_MEM with mem_to_reg = 1 and reg_we = 1. Total 8 cycles from FETCH entry.
- BC (opcode 19): br_taken = 1 -> pc_we = 1, pc_src = 1, alu_op = 01. Repeat with br_taken = 0 -> pc_we = 0, return to FETCH.
- Illegal: opcode 31 with XO = 3 -> TRAP, illegal = 1, busy = 0. Stays in TRAP for 10 cycles despite run = 1; cleared only by rst_n.
- Timeout/reset: mem_ready held 0 in MEM_WR with MEM_TIMEOUT = 4 -> bus_err = 1 after 4 cycles, then TRAP. Separately, assert rst_n = 0 during MEM_RD -> IDLE and mem_rd = 0 the next cycle.
